// File: rtl/test_monitor_if.sv
// Bus between the unit-test blocks and the test monitor.
// The monitor takes the slave side; the harness drives the master side.
interface test_monitor_if #(
  parameter int NUM_TESTS = 3,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = 4
);
  logic                 start;
  logic [NUM_TESTS-1:0] result_in;
  logic [NUM_TESTS-1:0] done_in;
  logic                 finished;
  logic                 pass;
  logic                 fail;
  logic                 timeout;
  logic [NUM_TESTS-1:0] fail_mask;
  logic [NUM_TESTS-1:0] done_mask;
  logic [IDX_W-1:0]     first_fail_idx;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, result_in, done_in,
    input  finished, pass, fail, timeout,
    input  fail_mask, done_mask,
    input  first_fail_idx, cycle_count
  );

  modport slave (
    input  start, result_in, done_in,
    output finished, pass, fail, timeout,
    output fail_mask, done_mask,
    output first_fail_idx, cycle_count
  );
endinterface

// File: rtl/test_monitor.sv
// Merges unit-test result/done pairs into one registered verdict,
// with start gating, sticky masks, first-failure index and watchdog.
module test_monitor #(
  parameter int NUM_TESTS      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16,
  parameter int IDX_W          = 4
) (
  input  logic           clk,
  input  logic           reset,
  test_monitor_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TMO
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_TESTS-1:0] fail_q;
  logic [NUM_TESTS-1:0] done_q;
  logic [NUM_TESTS-1:0] fail_nxt;
  logic [NUM_TESTS-1:0] done_nxt;
  logic [IDX_W-1:0]     ff_q;
  logic [IDX_W-1:0]     low_idx;
  logic [CNT_W-1:0]     cnt_q;
  logic                 all_done;
  logic                 any_fail;
  logic                 at_limit;

  assign fail_nxt = fail_q | bus.result_in;
  assign done_nxt = done_q | bus.done_in;
  assign all_done = &done_nxt;
  assign any_fail = |fail_nxt;
  assign at_limit = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (bus.result_in[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Completion is checked before the watchdog so a tie resolves to a verdict.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (all_done)      state_nxt = any_fail ? FAIL : PASS;
        else if (at_limit) state_nxt = TMO;
      end
      PASS, FAIL, TMO: state_nxt = state;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_q <= '0;
      done_q <= '0;
      ff_q   <= '0;
      cnt_q  <= '0;
    end else if (state == RUN) begin
      fail_q <= fail_nxt;
      done_q <= done_nxt;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (fail_q == '0 && bus.result_in != '0) ff_q <= low_idx;
    end
  end

  always_comb begin
    bus.pass     = state == PASS;
    bus.fail     = state == FAIL;
    bus.timeout  = state == TMO;
    bus.finished = bus.pass | bus.fail | bus.timeout;
  end

  assign bus.fail_mask      = fail_q;
  assign bus.done_mask      = done_q;
  assign bus.first_fail_idx = ff_q;
  assign bus.cycle_count    = cnt_q;

endmodule

// File: tb/tb_test_monitor.sv
// Directed and randomized checks of test_monitor against a
// schedule-level reference model (NUM_TESTS=3, TIMEOUT_CYCLES=20).
module tb_test_monitor;
  localparam int NT = 3;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [NT-1:0] sres  [0:TO];
  logic [NT-1:0] sdone [0:TO];

  test_monitor_if #(.NUM_TESTS(NT), .CNT_W(16), .IDX_W(4)) bus ();

  test_monitor #(
    .NUM_TESTS(NT), .TIMEOUT_CYCLES(TO), .CNT_W(16), .IDX_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int k = 0; k <= TO; k++) begin
      sres[k]  = '0;
      sdone[k] = '0;
    end
  endtask

  // Outcome of a schedule: 0 pass, 1 fail, 2 timeout.
  task automatic model(output int e, output int st,
                       output logic [NT-1:0] fm, output logic [NT-1:0] dm,
                       output logic [3:0] ff);
    bit found;
    fm = '0; dm = '0; ff = '0; e = TO; st = 2; found = 0;
    for (int k = 1; k <= TO; k++) begin
      if (!found && sres[k] != '0) begin
        found = 1;
        for (int b = 0; b < NT; b++)
          if (sres[k][b] && ff == 0 && !(b > 0 && sres[k][0])) begin
            ff = 4'(b);
            break;
          end
      end
      fm = fm | sres[k];
      dm = dm | sdone[k];
      if (dm == {NT{1'b1}}) begin
        e = k;
        st = (fm != '0) ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic check_final(string tag, int e, int st,
                             logic [NT-1:0] fm, logic [NT-1:0] dm,
                             logic [3:0] ff);
    chk({tag, ".finished"}, 32'(bus.finished), 32'd1);
    chk({tag, ".pass"}, 32'(bus.pass), 32'(st == 0));
    chk({tag, ".fail"}, 32'(bus.fail), 32'(st == 1));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(st == 2));
    chk({tag, ".fail_mask"}, 32'(bus.fail_mask), 32'(fm));
    chk({tag, ".done_mask"}, 32'(bus.done_mask), 32'(dm));
    chk({tag, ".first_fail"}, 32'(bus.first_fail_idx), 32'(ff));
    chk({tag, ".count"}, 32'(bus.cycle_count), 32'(e));
  endtask

  task automatic do_run(string tag, bit drop_start);
    int e, st;
    logic [NT-1:0] fm, dm;
    logic [3:0] ff;
    model(e, st, fm, dm, ff);
    bus.start = 1'b1;
    step();
    chk({tag, ".count0"}, 32'(bus.cycle_count), 32'd0);
    chk({tag, ".run_fin"}, 32'(bus.finished), 32'd0);
    if (drop_start) bus.start = 1'b0;
    for (int k = 1; k <= e; k++) begin
      bus.result_in = sres[k];
      bus.done_in   = sdone[k];
      step();
      chk({tag, ".count"}, 32'(bus.cycle_count), 32'(k));
      if (k < e) chk({tag, ".early"}, 32'(bus.finished), 32'd0);
    end
    check_final(tag, e, st, fm, dm, ff);
    for (int k = 0; k < 10; k++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.result_in = NT'($urandom);
      bus.done_in   = NT'($urandom);
      step();
    end
    check_final({tag, ".frz"}, e, st, fm, dm, ff);
    bus.start = 1'b0; bus.result_in = '0; bus.done_in = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.result_in = '0;
    bus.done_in = '0;
    #1;
    chk("rst.state", 32'({bus.finished, bus.pass, bus.fail, bus.timeout}), 32'd0);
    chk("rst.masks", 32'({bus.fail_mask, bus.done_mask}), 32'd0);
    chk("rst.idx", 32'(bus.first_fail_idx), 32'd0);
    chk("rst.count", 32'(bus.cycle_count), 32'd0);
    step();
    reset = 1'b0;

    // Idle gating: activity without start is ignored.
    for (int k = 0; k < 6; k++) begin
      bus.result_in = NT'($urandom);
      bus.done_in   = 3'b111;
      step();
    end
    chk("idle.masks", 32'({bus.fail_mask, bus.done_mask}), 32'd0);
    chk("idle.fin", 32'(bus.finished), 32'd0);
    chk("idle.count", 32'(bus.cycle_count), 32'd0);
    bus.result_in = '0; bus.done_in = '0;

    clear_sched();
    sdone[3] = 3'b001; sdone[5] = 3'b010; sdone[7] = 3'b100;
    do_run("allpass", 1'b1);
    pulse_reset();

    clear_sched();
    sres[2] = 3'b010;
    sdone[2] = 3'b001; sdone[4] = 3'b100; sdone[6] = 3'b010;
    do_run("single", 1'b0);
    pulse_reset();

    clear_sched();
    sres[2] = 3'b110; sres[4] = 3'b001; sdone[6] = 3'b111;
    do_run("simul", 1'b1);
    pulse_reset();

    clear_sched();
    sdone[3] = 3'b001; sdone[4] = 3'b010;
    do_run("hung", 1'b0);
    pulse_reset();

    clear_sched();
    sdone[5] = 3'b001; sdone[9] = 3'b100; sdone[20] = 3'b010;
    do_run("tie", 1'b1);
    pulse_reset();

    clear_sched();
    sres[20] = 3'b100; sdone[20] = 3'b111;
    do_run("lastfail", 1'b0);
    pulse_reset();

    // Asynchronous reset in the middle of RUN cycle 4.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.result_in = 3'b001;
      bus.done_in = 3'b010;
      step();
    end
    chk("mid.count_pre", 32'(bus.cycle_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.state", 32'({bus.finished, bus.pass, bus.fail, bus.timeout}), 32'd0);
    chk("mid.masks", 32'({bus.fail_mask, bus.done_mask}), 32'd0);
    chk("mid.idx", 32'(bus.first_fail_idx), 32'd0);
    chk("mid.count", 32'(bus.cycle_count), 32'd0);
    step();
    reset = 1'b0;
    bus.done_in = 3'b111;
    step();
    chk("mid.idle", 32'({bus.finished, bus.done_mask}), 32'd0);
    bus.result_in = '0; bus.done_in = '0;
    clear_sched();
    sdone[2] = 3'b111;
    do_run("restart", 1'b0);
    pulse_reset();

    for (int r = 0; r < 25; r++) begin
      int hung;
      hung = $urandom_range(0, 3);
      clear_sched();
      for (int k = 1; k <= TO; k++) begin
        if ($urandom_range(0, 7) == 0) sres[k] = NT'($urandom_range(1, 7));
        for (int b = 0; b < NT; b++)
          if ($urandom_range(0, 5) == 0 && b != hung) sdone[k][b] = 1'b1;
      end
      do_run("rand", 1'($urandom_range(0, 1)));
      pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
